// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg
// Shared definitions for the ALU operation sequencer: ALU control codes,
// ALUOp classes, R-type funct values, the sequencer FSM state enum and a
// small helper that flags immediate-shift control codes.
// Optional feature macro used by the importing files: ALU_SEQ_HILO_EN.
package alu_seq_pkg;

  // ALU control codes (4-bit native width, zero-extended at the top level)
  localparam logic [3:0] CTRL_AND     = 4'b0000;
  localparam logic [3:0] CTRL_OR      = 4'b0001;
  localparam logic [3:0] CTRL_ADD     = 4'b0010;
  localparam logic [3:0] CTRL_NOR     = 4'b0011;
  localparam logic [3:0] CTRL_SLTU    = 4'b0100;
  localparam logic [3:0] CTRL_SLL     = 4'b0101;
  localparam logic [3:0] CTRL_SUB     = 4'b0110;
  localparam logic [3:0] CTRL_SLT     = 4'b0111;
  localparam logic [3:0] CTRL_SRL     = 4'b1000;
  localparam logic [3:0] CTRL_SRA     = 4'b1001;
  localparam logic [3:0] CTRL_SRAV    = 4'b1010;
  localparam logic [3:0] CTRL_LUI     = 4'b1011;
  localparam logic [3:0] CTRL_MUL     = 4'b1100;
  localparam logic [3:0] CTRL_DIV     = 4'b1101;
  localparam logic [3:0] CTRL_ILLEGAL = 4'b1111;

  // ALUOp classes (low three bits)
  localparam logic [2:0] OP_ADD   = 3'b000;
  localparam logic [2:0] OP_SUB   = 3'b001;
  localparam logic [2:0] OP_RTYPE = 3'b010;
  localparam logic [2:0] OP_ADDI  = 3'b011;
  localparam logic [2:0] OP_SLTU  = 3'b100;
  localparam logic [2:0] OP_LUI   = 3'b101;
  localparam logic [2:0] OP_OR    = 3'b110;
  localparam logic [2:0] OP_AND   = 3'b111;

  // R-type funct values
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_DIV   = 6'b011010;
  localparam logic [5:0] FN_DIVU  = 6'b011011;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OUT  = 2'd1,
    ST_BUSY = 2'd2
  } seq_state_e;

  // Only the immediate shifts take their amount from the shamt field;
  // SRAV shifts by rs.
  function automatic logic is_shamt_shift(input logic [3:0] code);
    return (code == CTRL_SLL) || (code == CTRL_SRL) || (code == CTRL_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Purely combinational decode of (ALUOp, funct) into the 4-bit ALU control
// code plus side flags.
// Macro: ALU_SEQ_HILO_EN -- when undefined, the mult/div funct values decode
// as illegal and md_op_o / md_signed_o are constant 0.
// Ports:
//   alu_op_i    [OP_W-1:0] operation class; any bit above bit 2 is illegal
//   funct_i     [5:0]      R-type funct field
//   code_o      [3:0]      ALU control code
//   shamt_sel_o            1 = immediate shift (amount from shamt)
//   md_op_o                multi-cycle HI/LO operation (mult/div)
//   md_signed_o            signed mult/div
//   illegal_o              undecodable request
module alu_op_decode
  import alu_seq_pkg::*;
#(
  parameter int OP_W = 3
) (
  input  logic [OP_W-1:0] alu_op_i,
  input  logic [5:0]      funct_i,
  output logic [3:0]      code_o,
  output logic            shamt_sel_o,
  output logic            md_op_o,
  output logic            md_signed_o,
  output logic            illegal_o
);

  logic [3:0]      code;
  logic            op_hi;
  logic [OP_W-1:0] op_upper;

  // Shift rather than slice so the upper-bit check stays legal at OP_W == 3.
  assign op_upper = alu_op_i >> 3;
  assign op_hi    = |op_upper;

  always_comb begin
    code        = CTRL_ILLEGAL;
    md_op_o     = 1'b0;
    md_signed_o = 1'b0;
    if (!op_hi) begin
      case (alu_op_i[2:0])
        OP_ADD:   code = CTRL_ADD;
        OP_SUB:   code = CTRL_SUB;
        OP_ADDI:  code = CTRL_ADD;
        OP_SLTU:  code = CTRL_SLTU;
        OP_LUI:   code = CTRL_LUI;
        OP_OR:    code = CTRL_OR;
        OP_AND:   code = CTRL_AND;
        OP_RTYPE: begin
          case (funct_i)
            FN_ADD, FN_ADDU: code = CTRL_ADD;
            FN_SUB, FN_SUBU: code = CTRL_SUB;
            FN_AND:          code = CTRL_AND;
            FN_OR:           code = CTRL_OR;
            FN_NOR:          code = CTRL_NOR;
            FN_SLT:          code = CTRL_SLT;
            FN_SLTU:         code = CTRL_SLTU;
            FN_SLL:          code = CTRL_SLL;
            FN_SRL:          code = CTRL_SRL;
            FN_SRA:          code = CTRL_SRA;
            FN_SRAV:         code = CTRL_SRAV;
`ifdef ALU_SEQ_HILO_EN
            FN_MULT: begin
              code        = CTRL_MUL;
              md_op_o     = 1'b1;
              md_signed_o = 1'b1;
            end
            FN_MULTU: begin
              code    = CTRL_MUL;
              md_op_o = 1'b1;
            end
            FN_DIV: begin
              code        = CTRL_DIV;
              md_op_o     = 1'b1;
              md_signed_o = 1'b1;
            end
            FN_DIVU: begin
              code    = CTRL_DIV;
              md_op_o = 1'b1;
            end
`endif
            default:         code = CTRL_ILLEGAL;
          endcase
        end
        default: code = CTRL_ILLEGAL;
      endcase
    end
  end

  assign code_o      = code;
  assign illegal_o   = (code == CTRL_ILLEGAL);
  assign shamt_sel_o = is_shamt_shift(code);

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
// Registered ALU control decoder with valid/ready handshake. Single-cycle
// ops are presented one cycle after accept; mult/div ops hold the request
// side in BUSY for a fixed latency so upstream stall logic has a single
// back-pressure source.
// Macro: ALU_SEQ_HILO_EN -- builds mult/div decode, the BUSY state and the
// latency counter; undefined, ready_o is high whenever out of reset and
// md_start_o / md_signed_o are constant 0.
// Parameters: OP_W (>=3), CTRL_W (>=4), MUL_CYCLES (>=2), DIV_CYCLES (>=2).
// Ports:
//   clk_i, rst_i (synchronous, active-low)
//   valid_i / ready_o        request handshake (ready_o depends on state only)
//   ALUOp_i, funct_i         request
//   flush_i                  synchronous abort, wins over valid_i
//   valid_o                  registered outputs valid this cycle
//   ALUCtrl_o, shamt_sel_o   ALU control, shift-source select
//   md_start_o, md_signed_o  HI/LO unit start pulse and signedness
//   illegal_o                undecodable request, qualified by valid_o
//
// state   | meaning
// IDLE    | no result presented, ready for a request
// OUT     | result presented (valid_o=1), ready for the next request
// BUSY    | mult/div in flight, requests blocked, counter running
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int OP_W       = 3,
  parameter int CTRL_W     = 4,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [OP_W-1:0]   ALUOp_i,
  input  logic [5:0]        funct_i,
  input  logic              flush_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ALUCtrl_o,
  output logic              shamt_sel_o,
  output logic              md_start_o,
  output logic              md_signed_o,
  output logic              illegal_o
);

  logic [3:0] dec_code;
  logic       dec_shamt_sel;
  logic       dec_md_op;
  logic       dec_md_signed;
  logic       dec_illegal;

  alu_op_decode #(.OP_W(OP_W)) u_decode (
    .alu_op_i    (ALUOp_i),
    .funct_i     (funct_i),
    .code_o      (dec_code),
    .shamt_sel_o (dec_shamt_sel),
    .md_op_o     (dec_md_op),
    .md_signed_o (dec_md_signed),
    .illegal_o   (dec_illegal)
  );

  seq_state_e        state_q, state_d;
  logic              rst_done_q;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              shamt_q, shamt_d;
  logic              illegal_q, illegal_d;
  logic              accept;

`ifdef ALU_SEQ_HILO_EN
  // Counter is loaded with latency-2: one cycle is the accept edge itself,
  // and the terminal-count cycle still sits in BUSY.
  localparam int CNT_MAX = ((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) - 2;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, start_d;
  logic             md_signed_q, md_signed_d;

  // rst_done_q keeps ready_o low while reset is held.
  assign ready_o = rst_done_q && (state_q != ST_BUSY);
`else
  logic unused_md;
  assign unused_md = dec_md_op | dec_md_signed;
  assign ready_o   = rst_done_q;
`endif

  assign accept = valid_i && ready_o && !flush_i;

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    shamt_d   = shamt_q;
    illegal_d = illegal_q;
`ifdef ALU_SEQ_HILO_EN
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    md_signed_d = md_signed_q;
`endif
    case (state_q)
      ST_IDLE, ST_OUT: begin
        state_d = ST_IDLE;
        if (accept) begin
          state_d   = ST_OUT;
          ctrl_d    = CTRL_W'(dec_code);
          shamt_d   = dec_shamt_sel;
          illegal_d = dec_illegal;
`ifdef ALU_SEQ_HILO_EN
          md_signed_d = dec_md_signed;
          if (dec_md_op) begin
            state_d = ST_BUSY;
            start_d = 1'b1;
            cnt_d   = (dec_code == CTRL_MUL) ? CNT_W'(MUL_CYCLES - 2)
                                             : CNT_W'(DIV_CYCLES - 2);
          end
`endif
        end
      end
`ifdef ALU_SEQ_HILO_EN
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_OUT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // accept already excludes flush, so no start pulse can be generated here.
    if (flush_i) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q     <= ST_IDLE;
      rst_done_q  <= 1'b0;
      ctrl_q      <= '0;
      shamt_q     <= 1'b0;
      illegal_q   <= 1'b0;
`ifdef ALU_SEQ_HILO_EN
      cnt_q       <= '0;
      start_q     <= 1'b0;
      md_signed_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rst_done_q  <= 1'b1;
      ctrl_q      <= ctrl_d;
      shamt_q     <= shamt_d;
      illegal_q   <= illegal_d;
`ifdef ALU_SEQ_HILO_EN
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      md_signed_q <= md_signed_d;
`endif
    end
  end

  assign valid_o     = (state_q == ST_OUT);
  assign ALUCtrl_o   = ctrl_q;
  assign shamt_sel_o = shamt_q;
  assign illegal_o   = illegal_q;
`ifdef ALU_SEQ_HILO_EN
  assign md_start_o  = start_q;
  assign md_signed_o = md_signed_q;
`else
  assign md_start_o  = 1'b0;
  assign md_signed_o = 1'b0;
`endif

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered, parametrised successor to the combinational ALU control decoder in the MIPS datapath. It accepts an ALUOp/funct pair with a valid/ready handshake and emits a registered ALU control code plus shift-source select. It sequences multi-cycle multiply/divide operations with a fixed-latency busy window, so the stall logic upstream sees one source of back-pressure. It sits between the main Decoder and the ALU / HI-LO unit.

## Interface
- OP_W, 3: ALUOp width; must be ≥3; any set bit above bit 2 is illegal.
- CTRL_W, 4: ALU control width; must be ≥4; 4-bit codes are zero-extended.
- MUL_CYCLES, 4: multiply latency in cycles, from accept to valid_o; must be ≥2.
- DIV_CYCLES, 32: divide latency in cycles, from accept to valid_o; must be ≥2.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-low reset.
- valid_i  in  1  request valid.
- ready_o  out  1  request accepted when valid_i && ready_o at a rising edge.
- ALUOp_i  in  OP_W  operation class.
- funct_i  in  6  R-type funct field.
- flush_i  in  1  synchronous abort.
- valid_o  out  1  ALUCtrl_o/flags valid this cycle.
- ALUCtrl_o  out  CTRL_W  ALU control code.
- shamt_sel_o  out  1  1 = shift amount from shamt, 0 = from rs.
- md_start_o  out  1  one-cycle start pulse to the HI/LO unit.
- md_signed_o  out  1  signed mult/div.
- illegal_o  out  1  undecodable request, qualified by valid_o.

## Operation
ALUOp decode:
- 000 → ADD; 001 → SUB; 010 → funct decode; 011 → ADD; 100 → SLTU; 101 → LUI; 110 → OR; 111 → AND.

Control codes:
- AND 0000, OR 0001, ADD 0010, NOR 0011, SLTU 0100, SLL 0101, SUB 0110, SLT 0111, SRL 1000, SRA 1001, SRAV 1010, LUI 1011, MUL 1100, DIV 1101, ILLEGAL 1111.

Funct decode:
- 100000/100001 → ADD; 100010/100011 → SUB.
- 100100 → AND; 100101 → OR; 100111 → NOR.
- 101010 → SLT; 101011 → SLTU.
- 000000 → SLL; 000010 → SRL; 000011 → SRA; 000111 → SRAV.
- 011000/011001 → MUL, signed/unsigned.
- 011010/011011 → DIV, signed/unsigned.
- Any other funct → ILLEGAL, with illegal_o=1.

Outputs and flags:
- shamt_sel_o=1 only for SLL/SRL/SRA.
- md_signed_o=1 only for 011000/011010; it is 0 otherwise.

FSM states:
- IDLE: ready_o=1. A single-cycle op is accepted, moves to OUT, and is presented next cycle. A MUL/DIV op moves to BUSY.
- OUT: valid_o=1 for one cycle. ready_o=1, so back-to-back accepts are allowed at throughput 1. A new accept re-enters OUT/BUSY; otherwise go to IDLE.
- BUSY: ready_o=0, valid_i is ignored, and the down-counter runs. md_start_o=1 in the first BUSY cycle only. ALUCtrl_o and md_signed_o are held. At counter zero, go to OUT.

## Timing
- Reset: while rst_i=0 at an edge, valid_o, ready_o, md_start_o, illegal_o, shamt_sel_o and md_signed_o are all 0, ALUCtrl_o=0, and state=IDLE. ready_o=1 from the first cycle after reset deasserts.
- Single-cycle op accepted at edge T: valid_o=1 in cycle T+1. Latency is 1.
- MUL accepted at edge T:
  - md_start_o=1 in cycle T+1.
  - valid_o=1 in cycle T+MUL_CYCLES, with ready_o=1 in that same cycle.
  - ready_o=0 in cycles T+1 … T+MUL_CYCLES-1.
- DIV: same as MUL, with DIV_CYCLES.
- flush_i=1 at an edge: state goes to IDLE and valid_o=0 next cycle. Flush beats a simultaneous valid_i (no accept) and aborts BUSY with no further md_start_o.
- Illegal op: treated as single-cycle. valid_o=1 and illegal_o=1 at T+1.
- Outputs are registered only; there is no combinational input-to-output path except ready_o, which is a function of state only.

## Configuration
- ALU_SEQ_HILO_EN defined: MUL/DIV decode, the BUSY state and the counter are built as above.
- ALU_SEQ_HILO_EN undefined:
  - Funct 0110xx decodes to ILLEGAL.
  - There is no BUSY state or counter, and ready_o is tied high after reset.
  - md_start_o and md_signed_o are tied to 0.

## Structure
- Shared package alu_seq_pkg holds:
  - control-code localparams;
  - funct and ALUOp localparams;
  - the FSM state enum.
- Sub-module alu_op_decode: pure combinational decode of (ALUOp, funct) → {code, shamt_sel, md_op, md_signed, illegal}.
- The sequencer holds the FSM, counter and output registers.

## Test plan
- Reset with valid_i=1 held → all outputs 0. The first cycle after release has ready_o=1 and valid_o=0.
- Back-to-back R-type 100000, 100010, 000011 on consecutive edges → valid_o=1 for 3 cycles with ALUCtrl_o 0010, 0110, 1001. shamt_sel_o is 0, 0, 1.
- ALUOp=010, funct=011010, MUL_CYCLES=4, DIV_CYCLES=32 → md_start_o pulses at T+1 and md_signed_o=1. ready_o=0 for 31 cycles, then valid_o=1 with ALUCtrl_o=1101 at T+32. A valid_i held during BUSY is not accepted.
- flush_i asserted at the third BUSY cycle of a MUL → valid_o never rises for it, IDLE and ready_o=1 next cycle, and md_start_o does not re-pulse.
- funct=111111 with ALUOp=010, and separately ALUOp=1000 with OP_W=4 → valid_o=1, illegal_o=1, ALUCtrl_o=1111.
- Without ALU_SEQ_HILO_EN, funct=011000 → illegal_o=1 at T+1 and ready_o never drops.
